// File: rtl/task_answer_framer.sv
// task_answer_framer: pulls one answer packet per frame from the task output FIFO
// and emits it as SYNC, TASK_ID, LEN_HI, LEN_LO, payload, CSUM on a valid/ready
// byte stream. A 2-entry skid buffer absorbs the source's 1-cycle read latency.
module task_answer_framer #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter logic [7:0] TASK_ID   = 8'd8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_tanswer_ready,
    input  logic [7:0]  i_tdata,
    input  logic        i_tanswer_data_last,
    input  logic [11:0] i_packet_size_in_bytes,
    output logic        o_tmanager_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic        o_len_err,
    output logic [15:0] o_frame_cnt
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_PAY  = 2'd2;
    localparam logic [1:0] ST_CSUM = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  r_hdr_idx;
    logic [11:0] r_len;
    logic [11:0] r_req;
    logic [11:0] r_rcv;
    logic [11:0] r_cnt;
    logic        r_inflight;
    logic        r_last_seen;
    logic [7:0]  r_csum;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic        r_len_err;
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_skid [0:1];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_occ;

    logic        w_fire;
    logic        w_can_load;
    logic        w_last_now;
    logic [2:0]  w_pending;
    logic        w_rd_req;
    logic        w_rd_acc;
    logic        w_push;
    logic        w_pop;
    logic        w_frame_start;
    logic        w_len_ok;
    logic [7:0]  w_head;
    logic [7:0]  w_len_hi;

    assign w_fire        = r_tx_valid & i_tx_ready;
    assign w_can_load    = ~r_tx_valid | i_tx_ready;
    // The byte being captured this cycle may carry last; block a trailing read behind it.
    assign w_last_now    = r_inflight & i_tanswer_data_last;
    assign w_pending     = {1'b0, r_occ} + {2'b00, r_inflight};
    assign w_rd_req      = (r_state == ST_PAY) && (w_pending < 3'd2) && (r_req < r_len)
                           && !r_last_seen && !w_last_now;
    assign w_rd_acc      = w_rd_req & i_tanswer_ready;
    assign w_push        = r_inflight;
    assign w_pop         = (r_state == ST_PAY) && w_can_load && (r_cnt != r_len) && (r_occ != 2'd0);
    assign w_frame_start = (r_state == ST_IDLE) && i_tanswer_ready;
    assign w_len_ok      = r_last_seen && (r_rcv == r_len);
    assign w_head        = r_skid[r_rd_ptr];
    assign w_len_hi      = {4'h0, r_len[11:8]};

    assign o_tmanager_ready = w_rd_req;
    assign o_tx_data        = r_tx_data;
    assign o_tx_valid       = r_tx_valid;
    assign o_busy           = (r_state != ST_IDLE);
    assign o_len_err        = r_len_err;
    assign o_frame_cnt      = r_frame_cnt;

    // Read tracking and skid buffer: capture source bytes one cycle after each accepted read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req       <= '0;
            r_rcv       <= '0;
            r_inflight  <= 1'b0;
            r_last_seen <= 1'b0;
            r_skid[0]   <= '0;
            r_skid[1]   <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_occ       <= '0;
        end else if (w_frame_start) begin
            r_req       <= '0;
            r_rcv       <= '0;
            r_inflight  <= 1'b0;
            r_last_seen <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_occ       <= '0;
        end else begin
            r_inflight <= w_rd_acc;
            if (w_rd_acc) begin
                r_req <= r_req + 12'd1;
            end
            if (w_push) begin
                r_skid[r_wr_ptr] <= i_tdata;
                r_wr_ptr         <= ~r_wr_ptr;
                r_rcv            <= r_rcv + 12'd1;
                if (i_tanswer_data_last) begin
                    r_last_seen <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + 2'd1;
            end else if (!w_push && w_pop) begin
                r_occ <= r_occ - 2'd1;
            end
        end
    end

    // Framing FSM: the output register holds the presented byte; the checksum
    // accumulates as each non-SYNC byte is loaded, so it is complete when CSUM loads.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_hdr_idx   <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_csum      <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_len_err   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_len_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_tanswer_ready) begin
                        r_len      <= i_packet_size_in_bytes;
                        r_cnt      <= '0;
                        r_csum     <= '0;
                        r_hdr_idx  <= '0;
                        r_tx_data  <= SYNC_BYTE;
                        r_tx_valid <= 1'b1;
                        r_state    <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (w_fire) begin
                        case (r_hdr_idx)
                            2'd0: begin
                                r_tx_data <= TASK_ID;
                                r_csum    <= r_csum + TASK_ID;
                                r_hdr_idx <= 2'd1;
                            end
                            2'd1: begin
                                r_tx_data <= w_len_hi;
                                r_csum    <= r_csum + w_len_hi;
                                r_hdr_idx <= 2'd2;
                            end
                            2'd2: begin
                                r_tx_data <= r_len[7:0];
                                r_csum    <= r_csum + r_len[7:0];
                                r_hdr_idx <= 2'd3;
                            end
                            default: begin
                                if (r_len == 12'd0) begin
                                    r_tx_data <= r_csum;
                                    r_len_err <= 1'b1;
                                    r_state   <= ST_CSUM;
                                end else begin
                                    r_tx_valid <= 1'b0;
                                    r_state    <= ST_PAY;
                                end
                            end
                        endcase
                    end
                end
                ST_PAY: begin
                    if (w_can_load) begin
                        if (r_cnt == r_len) begin
                            r_tx_data  <= r_csum;
                            r_tx_valid <= 1'b1;
                            r_len_err  <= !w_len_ok;
                            r_state    <= ST_CSUM;
                        end else if (r_occ != 2'd0) begin
                            r_tx_data  <= w_head;
                            r_tx_valid <= 1'b1;
                            r_csum     <= r_csum + w_head;
                            r_cnt      <= r_cnt + 12'd1;
                        end else if (r_last_seen && !r_inflight) begin
                            r_tx_data  <= 8'h00;
                            r_tx_valid <= 1'b1;
                            r_cnt      <= r_cnt + 12'd1;
                        end else begin
                            r_tx_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (w_fire) begin
                        r_tx_valid  <= 1'b0;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Read gating keeps occupancy plus in-flight reads at two, so a full buffer never sees a push.
    assert property (@(posedge i_clk) disable iff (!i_rst_n) !(w_push && (r_occ == 2'd2)));

endmodule
